alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags and an iterative 1-bit shifter.
// Define ALU_BARREL_SHIFT_EN to make shifts single-cycle through a barrel shifter.
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   rs1_data,
  input  logic [WIDTH-1:0]   rs2_data,
  input  logic [WIDTH-1:0]   imm,
  input  logic               imm_sel,
  input  logic [2:0]         alu_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   res_q, res_nxt;
  logic [3:0]         flags_q, flags_nxt;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [2:0]         op, op_nxt;

  logic [WIDTH-1:0]   num2, b2, alu_res, shift_res, acc_sh;
  logic [WIDTH:0]     sum;
  logic [SHAMT_W-1:0] shamt;
  logic               cin, c_msb, is_arith, is_shift, long_shift;
  logic [3:0]         arith_flags;

  function automatic logic [WIDTH-1:0] shift1(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       o
  );
    if (o == OP_SLL)      return {v[WIDTH-2:0], 1'b0};
    else if (o == OP_SRL) return {1'b0, v[WIDTH-1:1]};
    else                  return {v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  function automatic logic [3:0] plain_flags(
    input logic [WIDTH-1:0] v
  );
    return {~|v, 2'b00, v[WIDTH-1]};
  endfunction

  assign num2     = imm_sel ? imm : rs2_data;
  assign is_arith = (alu_ctrl == OP_ADD) || (alu_ctrl == OP_SUB);
  assign is_shift = alu_ctrl[2] & (alu_ctrl[1] | alu_ctrl[0]);
  assign cin      = (alu_ctrl == OP_SUB);
  assign b2       = cin ? ~num2 : num2;
  assign sum      = {1'b0, rs1_data} + {1'b0, b2}
                  + {{WIDTH{1'b0}}, cin};
  // carry into the MSB recovered from the MSB sum bit
  assign c_msb    = sum[WIDTH-1] ^ rs1_data[WIDTH-1] ^ b2[WIDTH-1];
  assign shamt    = num2[SHAMT_W-1:0];

  assign arith_flags = {~|sum[WIDTH-1:0], sum[WIDTH],
                        sum[WIDTH] ^ c_msb, sum[WIDTH-1]};

`ifdef ALU_BARREL_SHIFT_EN
  always_comb begin
    shift_res = '0;
    unique case (1'b1)
      (alu_ctrl == OP_SLL): shift_res = rs1_data << shamt;
      (alu_ctrl == OP_SRL): shift_res = rs1_data >> shamt;
      default:              shift_res = WIDTH'($signed(rs1_data) >>> shamt);
    endcase
  end
  assign long_shift = 1'b0;
`else
  assign shift_res  = (shamt == '0) ? rs1_data
                                    : shift1(rs1_data, alu_ctrl);
  assign long_shift = is_shift && (shamt > SHAMT_W'(1));
`endif

  always_comb begin
    alu_res = shift_res;
    unique case (1'b1)
      is_arith:             alu_res = sum[WIDTH-1:0];
      (alu_ctrl == OP_AND): alu_res = rs1_data & num2;
      (alu_ctrl == OP_OR):  alu_res = rs1_data | num2;
      (alu_ctrl == OP_XOR): alu_res = rs1_data ^ num2;
      default:              alu_res = shift_res;
    endcase
  end

  assign acc_sh = shift1(res_q, op);

  always_comb begin
    state_nxt = state;
    res_nxt   = res_q;
    flags_nxt = flags_q;
    cnt_nxt   = cnt;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (in_valid) begin
          op_nxt  = alu_ctrl;
          res_nxt = alu_res;
          if (long_shift) begin
            cnt_nxt   = shamt - SHAMT_W'(1);
            state_nxt = SHIFT;
          end else begin
            flags_nxt = is_arith ? arith_flags
                                 : plain_flags(alu_res);
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        res_nxt = acc_sh;
        cnt_nxt = cnt - SHAMT_W'(1);
        if (cnt == SHAMT_W'(1)) begin
          flags_nxt = plain_flags(acc_sh);
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
      cnt     <= '0;
      op      <= OP_ADD;
    end else begin
      state   <= state_nxt;
      res_q   <= res_nxt;
      flags_q <= flags_nxt;
      cnt     <= cnt_nxt;
      op      <= op_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected result, flags and latency are
// queued at issue and compared when out_valid appears.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] rs1_data, rs2_data, imm;
  logic        imm_sel;
  logic [2:0]  alu_ctrl;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .imm_sel(imm_sel), .alu_ctrl(alu_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [2:0]  c);
    exp_t        e;
    logic [32:0] t;
    logic        cf, of;
    logic [4:0]  sh;
    cf = 1'b0;
    of = 1'b0;
    sh = b[4:0];
    t  = '0;
    case (c)
      3'd0: begin
        t   = {1'b0, a} + {1'b0, b};
        e.r = t[31:0];
        cf  = t[32];
        of  = (a[31] == b[31]) && (e.r[31] != a[31]);
      end
      3'd1: begin
        t   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.r = t[31:0];
        cf  = t[32];
        of  = (a[31] != b[31]) && (e.r[31] != a[31]);
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a | b;
      3'd4: e.r = a ^ b;
      3'd5: e.r = a << sh;
      3'd6: e.r = a >> sh;
      default: e.r = $signed(a) >>> sh;
    endcase
    e.f = {e.r == 32'd0, cf, of, e.r[31]};
`ifdef ALU_BARREL_SHIFT_EN
    e.lat = 1;
`else
    e.lat = (c >= 3'd5 && sh > 5'd1) ? int'(sh) : 1;
`endif
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic sel,
                       input logic [2:0] c);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 50) chk("ready_timeout", 0, 1);
    sb.push_back(model(a, sel ? im : b, c));
    rs1_data = a;
    rs2_data = b;
    imm      = im;
    imm_sel  = sel;
    alu_ctrl = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   lat;
    exp_t e;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("result", result, e.r);
    chk("flags", flags, e.f);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      rs1_data = 32'hDEAD_BEEF;
      alu_ctrl = 3'd4;
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_result", result, e.r);
      chk("hold_flags", flags, e.f);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] im, input logic sel,
                    input logic [2:0] c, input int hold);
    issue(a, b, im, sel, c);
    collect(hold);
  endtask

  initial begin
    exp_t junk;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    imm = '0;
    imm_sel = 1'b0;
    alu_ctrl = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);

    op(32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 3'd0, 0);
    op(32'd5, 32'h1234, 32'd5, 1'b1, 3'd1, 0);
    op(32'h1, 32'd31, 32'h0, 1'b0, 3'd5, 0);
    op(32'h8000_0000, 32'hFFFF_FFE4, 32'h0, 1'b0, 3'd7, 0);
    op(32'hA5A5_0000, 32'h0F0F_0F0F, 32'h0, 1'b0, 3'd3, 3);
    op(32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 3'd0, 0);
    op(32'd3, 32'd5, 32'h0, 1'b0, 3'd1, 0);
    op(32'h8000_0000, 32'h1, 32'h0, 1'b0, 3'd1, 0);
    op(32'hFFFF_0000, 32'h0, 32'hFF00_FF00, 1'b1, 3'd4, 0);
    op(32'hF000_000F, 32'h0, 32'h0, 1'b0, 3'd6, 0);
    op(32'hF000_000F, 32'h1, 32'h0, 1'b0, 3'd6, 0);
    op(32'h8000_0001, 32'h21, 32'h0, 1'b0, 3'd5, 0);
    op(32'h8765_4321, 32'h0, 32'd31, 1'b1, 3'd7, 0);
    op(32'hC000_0000, 32'd7, 32'h0, 1'b0, 3'd6, 1);
    for (int i = 0; i < 6; i++)
      op($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
         3'($urandom_range(0, 7)), 0);

    issue(32'h1, 32'd20, 32'h0, 1'b0, 3'd5);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    junk = sb.pop_front();
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_result", result, 0);
    chk("abort_flags", flags, 0);
    op(32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 3'd2, 0);
    chk("and_value", junk.lat > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
